stream_writer: RTL and testbench
================================

STREAM_WRITER -- requirements
Module: stream_writer

Interface
REQ-001 WRITE_STREAM_MAXSIZE, 230400, bytes per stream; multiple of 1024.
REQ-002 STREAM_ADDR_SHIFT, 2, extra address shift above $clog2(WRITE_STREAM_MAXSIZE) for stream base.
REQ-003 MAX_OUTSTANDING, 4, max bursts issued without BVALID/BREADY; range 1..15.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a run when idle.
REQ-007 num_streams  in  8  streams per run, sampled at start; 0 means 256.
REQ-008 iter_num  in  8  iteration tag, sampled at start.
REQ-009 busy  out  1  high from start acceptance until done.
REQ-010 done  out  1  one-cycle pulse after last B response of run.
REQ-011 error_detect  out  1  sticky; set on any BRESP != 0.
REQ-012 AWADDR  out  32  burst byte address.
REQ-013 AWID  out  4  burst ID, increments mod 16 per burst.
REQ-014 AWLEN/AWSIZE/AWBURST  out  8/3/2  constant 15 / 3'b110 / INCR.
REQ-015 AWVALID  out  1; AWREADY  in  1  write-address handshake.
REQ-016 WDATA  out  512  pattern beat.
REQ-017 WSTRB  out  64  constant all-ones.
REQ-018 WLAST  out  1  high on beat 15 of each burst.
REQ-019 WVALID  out  1; WREADY  in  1  write-data handshake.
REQ-020 BRESP  in  2; BVALID  in  1; BREADY  out  1 (tied high while busy).

Function
REQ-021 Stream s base address SHALL be s << (STREAM_ADDR_SHIFT + $clog2(WRITE_STREAM_MAXSIZE)) (bits [27:20] for defaults).
REQ-022 Each stream SHALL be written as WRITE_STREAM_MAXSIZE/1024 bursts (225) of 16 beats x 64 B, addresses base + 1024*n, ascending.
REQ-023 Beat b (0..3599) of stream s, 32-bit word k (0..15, word 0 at WDATA[31:0]) SHALL be {s[7:0], iter_num[7:0], (16*b + k)[15:0]}.
REQ-024 Beat counter SHALL reset to 0 at each new stream; word field wraps mod 2^16.
REQ-025 FSM states: IDLE, AW, W, DRAIN, DONE.
REQ-026 IDLE: start -> AW, latch inputs, stream=0, beat=0; start ignored when busy.
REQ-027 AW: AWVALID high only while outstanding < MAX_OUTSTANDING; on AWVALID&&AWREADY -> W.
REQ-028 W: WVALID high; beat advances on WVALID&&WREADY; after WLAST handshake -> AW, or DRAIN if last burst of last stream.
REQ-029 DRAIN: wait outstanding == 0 -> DONE; DONE: pulse done one cycle -> IDLE.
REQ-030 AWADDR/AWID/WDATA/WLAST SHALL be stable while VALID high and READY low; VALID never deasserted before handshake.
REQ-031 Outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged on simultaneous events; never exceeds MAX_OUTSTANDING.
REQ-032 B handshake when outstanding == 0 SHALL be ignored and set error_detect.
REQ-033 error_detect SHALL persist across runs; cleared only by reset.

Reset
REQ-034 Reset SHALL force IDLE, outstanding=0, counters=0, AWID=0, all VALID/BREADY/busy/done/error_detect low, AWADDR/WDATA=0.
REQ-035 Reset mid-burst SHALL abort immediately; no further AXI activity until next start.

Structure
REQ-036 Package stream_pkg SHALL hold WRITE_STREAM_MAXSIZE, STREAM_ADDR_SHIFT, beat/word widths, FSM state type; shared with the read monitor.
REQ-037 Sub-module stream_pattern_gen SHALL compute WDATA combinationally from {stream, iter, beat}.

Verification
REQ-038 num_streams=1, iter_num=8'h05, always-ready slave -> 225 bursts, first WDATA[63:0]=64'h00050001_00050000, last beat word 15 = 32'h0005E0FF, done once, error_detect=0.
REQ-039 num_streams=2 -> second stream first AWADDR=32'h0010_0000, word0=32'h01xx0000 (counter restarted).
REQ-040 Slave BVALID held off for 10 bursts, MAX_OUTSTANDING=4 -> AWVALID stalls after 4th burst; resumes on first B.
REQ-041 Random WREADY/AWREADY backpressure -> payload and addresses identical to no-backpressure run; VALID signals stable while stalled.
REQ-042 BRESP=2'b10 on burst 3 -> error_detect high from next cycle, run completes, persists until reset; reset asserted mid-W -> all outputs reset values next cycle.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared constants, FSM state type and data-pattern helper for the stream
// writer and its companion read monitor.
package stream_pkg;

   localparam int unsigned WRITE_STREAM_MAXSIZE = 230400;
   localparam int unsigned STREAM_ADDR_SHIFT    = 2;
   localparam int unsigned ADDR_LSB             = $clog2(WRITE_STREAM_MAXSIZE) + STREAM_ADDR_SHIFT;

   localparam int unsigned BURST_BYTES       = 1024;
   localparam int unsigned BURST_SHIFT       = $clog2(BURST_BYTES);
   localparam int unsigned BURSTS_PER_STREAM = WRITE_STREAM_MAXSIZE / BURST_BYTES;
   localparam int unsigned BEATS_PER_BURST   = 16;
   localparam int unsigned BEAT_IN_BURST_W   = $clog2(BEATS_PER_BURST);
   localparam int unsigned BEATS_PER_STREAM  = BURSTS_PER_STREAM * BEATS_PER_BURST;
   localparam int unsigned BEAT_W            = $clog2(BEATS_PER_STREAM);
   localparam int unsigned BURST_W           = $clog2(BURSTS_PER_STREAM);

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned WORDS_PER_BEAT = 16;
   localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_BEAT);
   localparam int unsigned DATA_W         = WORD_W * WORDS_PER_BEAT;
   localparam int unsigned STRB_W         = DATA_W / 8;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned ID_W           = 4;

   typedef enum logic [2:0] {IDLE, AW, W, DRAIN, DONE} state_e;

   // Word k of beat b carries a running 16-bit word count 16*b + k.
   function automatic logic [WORD_W-1:0] pattern_word(
      input logic [7:0]            stream,
      input logic [7:0]            iter,
      input logic [BEAT_W-1:0]     beat,
      input logic [WORD_IDX_W-1:0] k
   );
      logic [15:0] cnt;
      cnt = 16'({beat, k});
      return {stream, iter, cnt};
   endfunction

endpackage

// File: rtl/stream_writer_if.sv
// AXI write-channel bundle (AW, W, B) between the stream writer and memory.
interface stream_writer_if;
   import stream_pkg::*;

   logic [ADDR_W-1:0] AWADDR;
   logic [ID_W-1:0]   AWID;
   logic [7:0]        AWLEN;
   logic [2:0]        AWSIZE;
   logic [1:0]        AWBURST;
   logic              AWVALID;
   logic              AWREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WLAST;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;

   modport master (
      output AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
      output WDATA, WSTRB, WLAST, WVALID, BREADY,
      input  AWREADY, WREADY, BRESP, BVALID
   );

   modport slave (
      input  AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  WDATA, WSTRB, WLAST, WVALID, BREADY,
      output AWREADY, WREADY, BRESP, BVALID
   );

endinterface

// File: rtl/stream_pattern_gen.sv
// Combinational test-pattern generator: one full write beat from the current
// stream index, iteration tag and beat-within-stream counter.
module stream_pattern_gen
   import stream_pkg::*;
(
   input  logic [7:0]        stream,
   input  logic [7:0]        iter,
   input  logic [BEAT_W-1:0] beat,
   output logic [DATA_W-1:0] wdata
);

   always_comb begin
      wdata = '0;
      for (int unsigned k = 0; k < WORDS_PER_BEAT; k++) begin
         wdata[k*WORD_W +: WORD_W] = pattern_word(stream, iter, beat, WORD_IDX_W'(k));
      end
   end

endmodule

// File: rtl/stream_writer.sv
// Writes num_streams fixed-size pattern streams to memory as 16-beat INCR
// bursts, limiting the number of bursts awaiting a write response.
module stream_writer
   import stream_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] num_streams,
   input  logic [7:0] iter_num,
   output logic       busy,
   output logic       done,
   output logic       error_detect,
   stream_writer_if.master axi
);

   localparam int unsigned OUT_W = 4;

   state_e               state_q, state_d;
   logic [7:0]           last_stream_q, last_stream_d;
   logic [7:0]           iter_q, iter_d;
   logic [7:0]           stream_q, stream_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;
   logic [ID_W-1:0]      awid_q, awid_d;
   logic [OUT_W-1:0]     outstanding_q, outstanding_d;
   logic                 error_q, error_d;

   logic                 aw_valid, w_valid, busy_int, w_last;
   logic                 aw_hs, w_hs, b_hs, b_accept;
   logic [DATA_W-1:0]    pattern;

   stream_pattern_gen u_pattern (
      .stream (stream_q),
      .iter   (iter_q),
      .beat   (beat_q),
      .wdata  (pattern)
   );

   always_comb begin
      aw_valid = (state_q == AW) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
      w_valid  = (state_q == W);
      busy_int = (state_q != IDLE);
      w_last   = w_valid && (&beat_q[BEAT_IN_BURST_W-1:0]);
      aw_hs    = aw_valid && axi.AWREADY;
      w_hs     = w_valid && axi.WREADY;
      b_hs     = busy_int && axi.BVALID;
      b_accept = b_hs && (outstanding_q != '0);
   end

   assign axi.AWVALID = aw_valid;
   assign axi.AWADDR  = (ADDR_W'(stream_q) << ADDR_LSB) + (ADDR_W'(burst_q) << BURST_SHIFT);
   assign axi.AWID    = awid_q;
   assign axi.AWLEN   = 8'(BEATS_PER_BURST - 1);
   assign axi.AWSIZE  = 3'($clog2(DATA_W / 8));
   assign axi.AWBURST = 2'b01;
   assign axi.WVALID  = w_valid;
   assign axi.WDATA   = w_valid ? pattern : '0;
   assign axi.WSTRB   = '1;
   assign axi.WLAST   = w_last;
   assign axi.BREADY  = busy_int;

   assign busy         = busy_int;
   assign done         = (state_q == DONE);
   assign error_detect = error_q;

   always_comb begin
      state_d       = state_q;
      last_stream_d = last_stream_q;
      iter_d        = iter_q;
      stream_d      = stream_q;
      burst_d       = burst_q;
      beat_d        = beat_q;
      awid_d        = awid_q;
      outstanding_d = outstanding_q;
      error_d       = error_q;

      // A response with nothing outstanding is dropped but still flagged.
      if (b_hs && ((outstanding_q == '0) || (axi.BRESP != 2'b00))) begin
         error_d = 1'b1;
      end

      if (aw_hs && !b_accept) begin
         outstanding_d = outstanding_q + OUT_W'(1);
      end else if (!aw_hs && b_accept) begin
         outstanding_d = outstanding_q - OUT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = AW;
               last_stream_d = num_streams - 8'd1;
               iter_d        = iter_num;
               stream_d      = '0;
               burst_d       = '0;
               beat_d        = '0;
            end
         end
         AW: begin
            if (aw_hs) begin
               state_d = W;
               awid_d  = awid_q + ID_W'(1);
            end
         end
         W: begin
            if (w_hs) begin
               beat_d = beat_q + BEAT_W'(1);
               if (w_last) begin
                  state_d = AW;
                  if (burst_q == BURST_W'(BURSTS_PER_STREAM - 1)) begin
                     burst_d = '0;
                     beat_d  = '0;
                     if (stream_q == last_stream_q) begin
                        state_d = DRAIN;
                     end else begin
                        stream_d = stream_q + 8'd1;
                     end
                  end else begin
                     burst_d = burst_q + BURST_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            if (outstanding_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_stream_q <= '0;
         iter_q        <= '0;
         stream_q      <= '0;
         burst_q       <= '0;
         beat_q        <= '0;
         awid_q        <= '0;
         outstanding_q <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_stream_q <= last_stream_d;
         iter_q        <= iter_d;
         stream_q      <= stream_d;
         burst_q       <= burst_d;
         beat_q        <= beat_d;
         awid_q        <= awid_d;
         outstanding_q <= outstanding_d;
         error_q       <= error_d;
      end
   end

endmodule

// File: tb/tb_stream_writer.sv
// Directed bench for stream_writer: a responsive AXI slave with checking
// monitor, plus one task per scenario.
module tb_stream_writer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] num_streams;
   logic [7:0] iter_num;
   logic       busy;
   logic       done;
   logic       error_detect;

   stream_writer_if axi();

   stream_writer #(.MAX_OUTSTANDING(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_streams  (num_streams),
      .iter_num     (iter_num),
      .busy         (busy),
      .done         (done),
      .error_detect (error_detect),
      .axi          (axi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Test-process controls
   bit         rand_mode = 1'b0;
   bit         b_hold    = 1'b0;
   bit         spur_b    = 1'b0;
   int         err_idx   = 1000000;
   logic [7:0] run_iter  = 8'h00;

   // Slave/monitor state
   int           aw_cnt, w_cnt, b_cnt, pending, max_out, spur_cnt, done_cnt;
   int           data_err, addr_err, stab_err;
   logic [63:0]  first64;
   logic [31:0]  last_w15, s1_addr, s1_w0, exp_addr, exp_word;
   logic         err_before, err_after, err_chk, spur_sent;
   logic         stall_aw, stall_w, p_wlast;
   logic [31:0]  p_awaddr;
   logic [3:0]   p_awid, exp_awid;
   logic [511:0] p_wdata;

   initial begin : slave
      axi.AWREADY = 1'b0;
      axi.WREADY  = 1'b0;
      axi.BVALID  = 1'b0;
      axi.BRESP   = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; pending = 0; max_out = 0; spur_cnt = 0; done_cnt = 0;
            data_err = 0; addr_err = 0; stab_err = 0;
            first64 = '0; last_w15 = '0; s1_addr = '0; s1_w0 = '0;
            err_before = 1'b0; err_after = 1'b0; err_chk = 1'b0; spur_sent = 1'b0;
            stall_aw = 1'b0; stall_w = 1'b0; p_wlast = 1'b0; p_awaddr = '0; p_awid = '0;
            p_wdata = '0; exp_awid = '0;
         end else begin
            if (done) done_cnt++;
            if (err_chk) begin
               err_after = error_detect;
               err_chk   = 1'b0;
            end
            if (stall_aw && (!axi.AWVALID || axi.AWADDR !== p_awaddr || axi.AWID !== p_awid)) stab_err++;
            if (stall_w && (!axi.WVALID || axi.WDATA !== p_wdata || axi.WLAST !== p_wlast)) stab_err++;

            axi.AWREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.WREADY  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spur_b && !spur_sent) begin
               axi.BVALID = 1'b1;
               axi.BRESP  = 2'b00;
               spur_sent  = 1'b1;
            end else begin
               axi.BVALID = (pending > 0) && !b_hold;
               axi.BRESP  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
            end

            if (axi.BVALID && axi.BREADY) begin
               if (pending == 0) begin
                  spur_cnt++;
               end else begin
                  pending--;
                  if (axi.BRESP != 2'b00) begin
                     err_before = error_detect;
                     err_chk    = 1'b1;
                  end
                  b_cnt++;
               end
            end

            if (axi.AWVALID && axi.AWREADY) begin
               exp_addr = 32'(((aw_cnt / 225) << 20) + (aw_cnt % 225) * 1024);
               if (axi.AWADDR !== exp_addr || axi.AWID !== exp_awid || axi.AWLEN !== 8'd15 ||
                   axi.AWSIZE !== 3'b110 || axi.AWBURST !== 2'b01) addr_err++;
               if (aw_cnt == 225) s1_addr = axi.AWADDR;
               exp_awid = exp_awid + 4'd1;
               aw_cnt++;
               pending++;
               if (pending > max_out) max_out = pending;
            end

            if (axi.WVALID && axi.WREADY) begin
               for (int k = 0; k < 16; k++) begin
                  exp_word = {8'(w_cnt / 3600), run_iter, 16'((w_cnt % 3600) * 16 + k)};
                  if (axi.WDATA[k*32 +: 32] !== exp_word) data_err++;
               end
               if (axi.WLAST !== ((w_cnt % 16) == 15) || axi.WSTRB !== {64{1'b1}}) data_err++;
               if (w_cnt == 0) first64 = axi.WDATA[63:0];
               if (w_cnt == 3600) s1_w0 = axi.WDATA[31:0];
               last_w15 = axi.WDATA[511:480];
               w_cnt++;
            end

            stall_aw = axi.AWVALID && !axi.AWREADY;
            stall_w  = axi.WVALID && !axi.WREADY;
            p_awaddr = axi.AWADDR;
            p_awid   = axi.AWID;
            p_wdata  = axi.WDATA;
            p_wlast  = axi.WLAST;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic start_run(input logic [7:0] ns, input logic [7:0] it);
      num_streams = ns;
      iter_num    = it;
      run_iter    = it;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      ok = (done_cnt >= target);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_tests++; if ({busy, done, error_detect} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, error_detect}); end
      n_tests++; if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b expected 000", {axi.AWVALID, axi.WVALID, axi.BREADY}); end
      n_tests++; if (axi.AWADDR !== 32'h0) begin n_fail++; $display("FAIL reset_awaddr: got %h expected 0", axi.AWADDR); end
      n_tests++; if (axi.AWID !== 4'h0) begin n_fail++; $display("FAIL reset_awid: got %h expected 0", axi.AWID); end
      n_tests++; if (axi.WDATA !== 512'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", axi.WDATA[63:0]); end
      reset = 1'b0;
      repeat (3) tick();
      n_tests++; if ({busy, axi.AWVALID} !== 2'b00) begin n_fail++; $display("FAIL idle_no_start: got %b expected 00", {busy, axi.AWVALID}); end
   endtask

   task automatic test_single_stream();
      bit ok;
      do_reset();
      start_run(8'd1, 8'h05);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
      wait_done(1, 6000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: done_cnt %0d expected 1", done_cnt); end
      n_tests++; if (aw_cnt !== 225 || w_cnt !== 3600 || b_cnt !== 225) begin n_fail++; $display("FAIL single_counts: got aw %0d w %0d b %0d expected 225 3600 225", aw_cnt, w_cnt, b_cnt); end
      n_tests++; if (first64 !== 64'h00050001_00050000) begin n_fail++; $display("FAIL single_first64: got %h expected 0005000100050000", first64); end
      n_tests++; if (last_w15 !== 32'h0005E0FF) begin n_fail++; $display("FAIL single_last_w15: got %h expected 0005e0ff", last_w15); end
      n_tests++; if (data_err !== 0 || addr_err !== 0) begin n_fail++; $display("FAIL single_payload: got data_err %0d addr_err %0d expected 0 0", data_err, addr_err); end
      repeat (3) tick();
      n_tests++; if (done_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done_once: got done_cnt %0d busy %b expected 1 0", done_cnt, busy); end
      n_tests++; if (error_detect !== 1'b0) begin n_fail++; $display("FAIL single_no_error: got %b expected 0", error_detect); end
   endtask

   task automatic test_two_streams();
      bit ok;
      do_reset();
      start_run(8'd2, 8'hA3);
      wait_done(1, 12000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL two_timeout: done_cnt %0d expected 1", done_cnt); end
      n_tests++; if (aw_cnt !== 450 || w_cnt !== 7200) begin n_fail++; $display("FAIL two_counts: got aw %0d w %0d expected 450 7200", aw_cnt, w_cnt); end
      n_tests++; if (s1_addr !== 32'h0010_0000) begin n_fail++; $display("FAIL two_s1_addr: got %h expected 00100000", s1_addr); end
      n_tests++; if (s1_w0 !== 32'h01A30000) begin n_fail++; $display("FAIL two_s1_word0: got %h expected 01a30000", s1_w0); end
      n_tests++; if (last_w15 !== 32'h01A3E0FF) begin n_fail++; $display("FAIL two_last_w15: got %h expected 01a3e0ff", last_w15); end
      n_tests++; if (data_err !== 0 || addr_err !== 0) begin n_fail++; $display("FAIL two_payload: got data_err %0d addr_err %0d expected 0 0", data_err, addr_err); end
   endtask

   task automatic test_backpressure();
      bit ok;
      do_reset();
      rand_mode = 1'b1;
      start_run(8'd1, 8'h5A);
      wait_done(1, 14000, ok);
      rand_mode = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: done_cnt %0d expected 1", done_cnt); end
      n_tests++; if (aw_cnt !== 225 || w_cnt !== 3600) begin n_fail++; $display("FAIL bp_counts: got aw %0d w %0d expected 225 3600", aw_cnt, w_cnt); end
      n_tests++; if (first64 !== 64'h005A0001_005A0000 || last_w15 !== 32'h005AE0FF) begin n_fail++; $display("FAIL bp_ends: got %h %h expected 005a0001005a0000 005ae0ff", first64, last_w15); end
      n_tests++; if (data_err !== 0 || addr_err !== 0) begin n_fail++; $display("FAIL bp_payload: got data_err %0d addr_err %0d expected 0 0", data_err, addr_err); end
      n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stability: got %0d expected 0", stab_err); end
   endtask

   task automatic test_outstanding();
      bit ok;
      int n;
      do_reset();
      b_hold = 1'b1;
      start_run(8'd1, 8'h11);
      repeat (150) tick();
      n_tests++; if (aw_cnt !== 4 || b_cnt !== 0) begin n_fail++; $display("FAIL out_stall_count: got aw %0d b %0d expected 4 0", aw_cnt, b_cnt); end
      n_tests++; if ({busy, axi.AWVALID} !== 2'b10) begin n_fail++; $display("FAIL out_stall_valid: got busy,awvalid %b expected 10", {busy, axi.AWVALID}); end
      b_hold = 1'b0;
      n = 0;
      while (aw_cnt < 5 && n < 20) begin
         tick();
         n++;
      end
      n_tests++; if (aw_cnt < 5) begin n_fail++; $display("FAIL out_resume: got aw %0d expected 5", aw_cnt); end
      wait_done(1, 6000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL out_timeout: done_cnt %0d expected 1", done_cnt); end
      n_tests++; if (max_out !== 4 || b_cnt !== 225) begin n_fail++; $display("FAIL out_max: got max %0d b %0d expected 4 225", max_out, b_cnt); end
      n_tests++; if (data_err !== 0 || addr_err !== 0) begin n_fail++; $display("FAIL out_payload: got data_err %0d addr_err %0d expected 0 0", data_err, addr_err); end
   endtask

   task automatic test_error();
      bit ok;
      do_reset();
      err_idx = 3;
      start_run(8'd1, 8'h22);
      wait_done(1, 6000, ok);
      err_idx = 1000000;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL err_timeout: done_cnt %0d expected 1", done_cnt); end
      n_tests++; if ({err_before, err_after} !== 2'b01) begin n_fail++; $display("FAIL err_timing: got before,after %b expected 01", {err_before, err_after}); end
      n_tests++; if (error_detect !== 1'b1 || b_cnt !== 225) begin n_fail++; $display("FAIL err_after_run: got err %b b %0d expected 1 225", error_detect, b_cnt); end
      start_run(8'd1, 8'h23);
      repeat (5) tick();
      n_tests++; if ({busy, error_detect} !== 2'b11) begin n_fail++; $display("FAIL err_persist: got busy,err %b expected 11", {busy, error_detect}); end
      do_reset();
      n_tests++; if (error_detect !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", error_detect); end
   endtask

   task automatic test_spurious_b();
      int n;
      do_reset();
      start_run(8'd1, 8'h44);
      spur_b = 1'b1;
      repeat (3) tick();
      n_tests++; if (spur_cnt !== 1 || error_detect !== 1'b1) begin n_fail++; $display("FAIL spur_flag: got spur %0d err %b expected 1 1", spur_cnt, error_detect); end
      n = 0;
      while (aw_cnt < 6 && n < 300) begin
         tick();
         n++;
      end
      n_tests++; if (aw_cnt < 6) begin n_fail++; $display("FAIL spur_progress: got aw %0d expected 6", aw_cnt); end
      spur_b = 1'b0;
      do_reset();
   endtask

   task automatic test_reset_mid_w();
      int n;
      do_reset();
      start_run(8'd1, 8'h33);
      n = 0;
      while (!(w_cnt >= 40 && axi.WVALID === 1'b1) && n < 300) begin
         tick();
         n++;
      end
      n_tests++; if (axi.WVALID !== 1'b1) begin n_fail++; $display("FAIL midw_reach: got wvalid %b expected 1", axi.WVALID); end
      reset = 1'b1;
      #1;
      n_tests++; if ({busy, done, error_detect, axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY} !== 7'b0) begin n_fail++; $display("FAIL midw_ctrl: got %b expected 0000000", {busy, done, error_detect, axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY}); end
      n_tests++; if (axi.AWADDR !== 32'h0 || axi.AWID !== 4'h0) begin n_fail++; $display("FAIL midw_aw: got %h %h expected 0 0", axi.AWADDR, axi.AWID); end
      n_tests++; if (axi.WDATA !== 512'h0) begin n_fail++; $display("FAIL midw_wdata: got %h expected 0", axi.WDATA[63:0]); end
      tick();
      tick();
      reset = 1'b0;
      repeat (20) tick();
      n_tests++; if (aw_cnt !== 0 || w_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midw_quiet: got aw %0d w %0d busy %b expected 0 0 0", aw_cnt, w_cnt, busy); end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      num_streams = 8'd1;
      iter_num    = 8'h00;
      test_reset();
      test_single_stream();
      test_two_streams();
      test_backpressure();
      test_outstanding();
      test_error();
      test_spurious_b();
      test_reset_mid_w();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
